// File: rtl/hall_if.sv
// Phase-drive / Hall-feedback bundle between a motor driver (master) and the rotor model (slave).
interface hall_if #(
    parameter int CNT_W = 16
) ();
    logic             en;
    logic [CNT_W-1:0] dwell;
    logic [1:0]       A;
    logic [1:0]       B;
    logic [1:0]       C;
    logic [2:0]       H;
    logic             dir;
    logic             moving;
    logic             fault;
    logic [15:0]      pos;

    modport master (
        output en, dwell, A, B, C,
        input  H, dir, moving, fault, pos
    );

    modport slave (
        input  en, dwell, A, B, C,
        output H, dir, moving, fault, pos
    );
endinterface

// File: rtl/hall_sensor_emulator.sv
// BLDC rotor model: watches six-step phase drive and advances the Hall sector after
// the drive has been held in a torque-producing pattern for a programmable dwell.
module hall_sensor_emulator #(
    parameter int INIT_IDX = 0,
    parameter int CNT_W    = 16
) (
    input  logic  clk,
    input  logic  rst,
    hall_if.slave bus
);

    typedef enum logic [1:0] {
        M_NONE = 2'd0,
        M_FWD  = 2'd1,
        M_REV  = 2'd2
    } match_e;

    logic [2:0]       idx_q, idx_d;
    logic [2:0]       h_q, h_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             moving_q, moving_d;
    logic             fault_q, fault_d;
    logic [15:0]      pos_q, pos_d;
    match_e           last_q, last_d;

    logic [5:0]       drive;
    logic             shoot;
    logic             match_f;
    logic             match_r;
    logic             flip;
    logic [CNT_W-1:0] dwell_m1;
    logic [CNT_W-1:0] cnt_base;
    logic             at_tc;
    logic [2:0]       idx_inc;
    logic [2:0]       idx_dec;

    // Drive packed as {A,B,C}; each phase is {high-side, low-side}.
    function automatic logic [5:0] fwd_pat(input logic [2:0] i);
        logic [5:0] p;
        case (i)
            3'd0:    p = 6'b10_00_01;
            3'd1:    p = 6'b00_10_01;
            3'd2:    p = 6'b01_10_00;
            3'd3:    p = 6'b01_00_10;
            3'd4:    p = 6'b00_01_10;
            3'd5:    p = 6'b10_01_00;
            default: p = 6'b00_00_00;
        endcase
        return p;
    endfunction

    function automatic logic [5:0] rev_pat(input logic [2:0] i);
        logic [5:0] f;
        f = fwd_pat(i);
        return {f[4], f[5], f[2], f[3], f[0], f[1]};
    endfunction

    function automatic logic [2:0] hall_of(input logic [2:0] i);
        logic [2:0] h;
        case (i)
            3'd0:    h = 3'b101;
            3'd1:    h = 3'b100;
            3'd2:    h = 3'b110;
            3'd3:    h = 3'b010;
            3'd4:    h = 3'b011;
            3'd5:    h = 3'b001;
            default: h = 3'b000;
        endcase
        return h;
    endfunction

    always_comb begin
        drive    = {bus.A, bus.B, bus.C};
        shoot    = (bus.A == 2'b11) || (bus.B == 2'b11) || (bus.C == 2'b11);
        match_f  = (drive == fwd_pat(idx_q));
        match_r  = (drive == rev_pat(idx_q));
        // A F<->R flip discards the partial dwell; the flipping cycle counts as the first.
        flip     = (match_f && last_q == M_REV) || (match_r && last_q == M_FWD);
        cnt_base = flip ? '0 : cnt_q;
        dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - CNT_W'(1);
        at_tc    = (cnt_base >= dwell_m1);
        idx_inc  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        idx_dec  = (idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1;

        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        fault_d  = fault_q;
        pos_d    = pos_q;
        last_d   = last_q;

        if (shoot) begin
            fault_d  = 1'b1;
            cnt_d    = '0;
            moving_d = 1'b0;
            last_d   = M_NONE;
        end else if (fault_q) begin
            cnt_d    = '0;
            moving_d = 1'b0;
            last_d   = M_NONE;
        end else if (!bus.en) begin
            moving_d = 1'b0;
        end else if (match_f) begin
            moving_d = 1'b1;
            last_d   = M_FWD;
            if (at_tc) begin
                idx_d = idx_inc;
                pos_d = pos_q + 16'd1;
                dir_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end else if (match_r) begin
            moving_d = 1'b1;
            last_d   = M_REV;
            if (at_tc) begin
                idx_d = idx_dec;
                pos_d = pos_q - 16'd1;
                dir_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end else begin
            cnt_d    = '0;
            moving_d = 1'b0;
            last_d   = M_NONE;
        end

        h_d = hall_of(idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= 3'(INIT_IDX);
            h_q      <= hall_of(3'(INIT_IDX));
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            moving_q <= 1'b0;
            fault_q  <= 1'b0;
            pos_q    <= '0;
            last_q   <= M_NONE;
        end else begin
            idx_q    <= idx_d;
            h_q      <= h_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            fault_q  <= fault_d;
            pos_q    <= pos_d;
            last_q   <= last_d;
        end
    end

    assign bus.H      = h_q;
    assign bus.dir    = dir_q;
    assign bus.moving = moving_q;
    assign bus.fault  = fault_q;
    assign bus.pos    = pos_q;

endmodule
